// File: rtl/mult_collect_pkg.sv
// Shared types and helpers for the multiplier result collector.
package mult_collect_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic signed [31:0] result;
        logic               arg_err;
        logic               res_err;
    } t_res_entry;

    function automatic logic even_par32(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; read data is the head register, valid whenever not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mult_result_collector.sv
// Captures multiplier results on result_rdy rising edges, tags parity errors,
// buffers them for a valid/ready consumer and keeps saturating statistics.
module mult_result_collector
    import mult_collect_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            result,
    input  logic                   result_parity,
    input  logic                   result_rdy,
    input  logic                   arg_parity_error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic                   out_arg_err,
    output logic                   out_res_err,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       cnt_results,
    output logic [CNT_W-1:0]       cnt_par_err,
    output logic [CNT_W-1:0]       cnt_drop
);

    logic       rdy_q;
    logic       capture;
    logic       pop;
    logic       drop;
    logic       full;
    logic       empty;
    t_res_entry entry;
    t_res_entry head;

    assign capture = result_rdy & ~rdy_q;
    assign pop     = out_ready & ~empty;
    assign drop    = capture & full & ~pop;

    // A flagged operand makes the product meaningless, so it is stored as zero.
    always_comb begin
        entry         = '0;
        entry.arg_err = arg_parity_error;
        if (!arg_parity_error) begin
            entry.result  = result;
            entry.res_err = even_par32(result) ^ result_parity;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(t_res_entry)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (pop),
        .wdata (entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign out_valid   = ~empty;
    assign out_result  = head.result;
    assign out_arg_err = head.arg_err;
    assign out_res_err = head.res_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            cnt_results <= '0;
            cnt_par_err <= '0;
            cnt_drop    <= '0;
        end else begin
            rdy_q <= result_rdy;
            if (capture && cnt_results != '1) begin
                cnt_results <= cnt_results + CNT_W'(1);
            end
            if (capture && (entry.arg_err | entry.res_err) && cnt_par_err != '1) begin
                cnt_par_err <= cnt_par_err + CNT_W'(1);
            end
            if (drop && cnt_drop != '1) begin
                cnt_drop <= cnt_drop + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_result_collector.sv
// Directed bench for mult_result_collector with a queue-based reference model.
module tb_mult_result_collector;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [31:0]      result;
    logic             result_parity;
    logic             result_rdy;
    logic             arg_parity_error;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_arg_err;
    logic             out_res_err;
    logic [LW-1:0]    fifo_level;
    logic [CNT_W-1:0] cnt_results;
    logic [CNT_W-1:0] cnt_par_err;
    logic [CNT_W-1:0] cnt_drop;

    mult_result_collector #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .result           (result),
        .result_parity    (result_parity),
        .result_rdy       (result_rdy),
        .arg_parity_error (arg_parity_error),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_arg_err      (out_arg_err),
        .out_res_err      (out_res_err),
        .fifo_level       (fifo_level),
        .cnt_results      (cnt_results),
        .cnt_par_err      (cnt_par_err),
        .cnt_drop         (cnt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        a;
        logic        e;
    } ent_t;

    ent_t        mq[$];
    int          m_res;
    int          m_perr;
    int          m_drop;
    logic        m_rdy_q;
    logic        m_cap;
    logic        m_pop;
    ent_t        m_e;

    int          vectors;
    int          miscompares;
    logic        chk_en;
    logic        tgl;
    logic [31:0] deliv[$];
    logic        prev_valid;
    logic [31:0] prev_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of what the consumer must see, plus counters.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_res   = 0;
            m_perr  = 0;
            m_drop  = 0;
            m_rdy_q = 1'b0;
        end else begin
            m_cap   = result_rdy && !m_rdy_q;
            m_rdy_q = result_rdy;
            m_pop   = (mq.size() != 0) && out_ready;
            if (m_cap) begin
                if (arg_parity_error) begin
                    m_e.r = 32'd0; m_e.a = 1'b1; m_e.e = 1'b0;
                end else begin
                    m_e.r = result; m_e.a = 1'b0; m_e.e = (^result) != result_parity;
                end
                if (m_res < CMAX) m_res++;
                if ((m_e.a || m_e.e) && m_perr < CMAX) m_perr++;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_cap) begin
                if (mq.size() < DEPTH) mq.push_back(m_e);
                else if (m_drop < CMAX) m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (prev_valid && out_ready) deliv.push_back(prev_res);
            if (!rst && prev_valid && !out_ready && out_valid)
                check("hold_result", out_result, prev_res);
            check("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("out_result", out_result, mq[0].r);
                check("out_arg_err", out_arg_err, mq[0].a);
                check("out_res_err", out_res_err, mq[0].e);
            end
            check("fifo_level", fifo_level, mq.size());
            check("cnt_results", cnt_results, m_res);
            check("cnt_par_err", cnt_par_err, m_perr);
            check("cnt_drop", cnt_drop, m_drop);
            prev_valid = out_valid;
            prev_res   = out_result;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (tgl) out_ready = ~out_ready;
    endtask

    task automatic pulse(input logic [31:0] v);
        result           = v;
        result_parity    = ^v;
        arg_parity_error = 1'b0;
        result_rdy       = 1'b1;
        tick();
        result_rdy       = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vectors          = 0;
        miscompares      = 0;
        chk_en           = 1'b0;
        tgl              = 1'b0;
        prev_valid       = 1'b0;
        prev_res         = '0;
        rst              = 1'b1;
        result           = '0;
        result_parity    = 1'b0;
        result_rdy       = 1'b0;
        arg_parity_error = 1'b0;
        out_ready        = 1'b0;
        repeat (2) tick();

        check("rst_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_result", out_result, 0);
        check("rst_cnt_results", cnt_results, 0);
        check("rst_cnt_drop", cnt_drop, 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // Single result held three cycles
        out_ready     = 1'b1;
        result        = 32'h0000_0006;
        result_parity = 1'b0;
        result_rdy    = 1'b1;
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_result", out_result, 32'h6);
        check("t1_res_err", out_res_err, 0);
        tick();
        tick();
        result_rdy = 1'b0;
        tick();
        check("t1_cnt_results", cnt_results, 1);
        check("t1_cnt_par_err", cnt_par_err, 0);
        check("t1_empty", out_valid, 0);

        // Parity mismatch, then operand error
        result        = 32'hFFFF_FFFE;
        result_parity = 1'b0;
        result_rdy    = 1'b1;
        tick();
        check("t2_result", out_result, 32'hFFFF_FFFE);
        check("t2_res_err", out_res_err, 1);
        result_rdy = 1'b0;
        tick();
        result           = 32'h0000_1234;
        arg_parity_error = 1'b1;
        result_rdy       = 1'b1;
        tick();
        check("t2_arg_result", out_result, 0);
        check("t2_arg_err", out_arg_err, 1);
        check("t2_arg_res_err", out_res_err, 0);
        result_rdy       = 1'b0;
        arg_parity_error = 1'b0;
        tick();
        check("t2_cnt_par_err", cnt_par_err, 2);
        check("t2_cnt_results", cnt_results, 3);

        // Overflow: five pulses into a four-entry FIFO
        out_ready = 1'b0;
        for (int unsigned v = 1; v <= 5; v++) pulse(v);
        check("t3_level", fifo_level, 4);
        check("t3_cnt_drop", cnt_drop, 1);
        out_ready = 1'b1;
        for (int unsigned v = 1; v <= 4; v++) begin
            check("t3_drain", out_result, v);
            tick();
        end
        check("t3_empty", out_valid, 0);

        // Capture and pop in the same cycle while full
        out_ready = 1'b0;
        for (int unsigned v = 10; v <= 13; v++) pulse(v);
        check("t4_full", fifo_level, 4);
        result        = 32'd14;
        result_parity = ^result;
        result_rdy    = 1'b1;
        out_ready     = 1'b1;
        tick();
        result_rdy = 1'b0;
        out_ready  = 1'b0;
        check("t4_level", fifo_level, 4);
        check("t4_cnt_drop", cnt_drop, 1);
        tick();
        out_ready = 1'b1;
        for (int unsigned v = 11; v <= 14; v++) begin
            check("t4_drain", out_result, v);
            tick();
        end
        check("t4_empty", out_valid, 0);
        check("t4_cnt_results", cnt_results, 13);

        // Backpressure toggling every cycle over eight results
        base      = deliv.size();
        out_ready = 1'b0;
        tgl       = 1'b1;
        for (int unsigned k = 0; k < 8; k++) pulse(100 + k);
        repeat (12) tick();
        tgl       = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("t5_count", deliv.size() - base, 8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < deliv.size())
                check("t5_order", deliv[base + k], 100 + k);
        end
        check("t5_cnt_sat", cnt_results, CMAX);
        check("t5_cnt_drop", cnt_drop, 1);

        // Reset while entries are buffered and result_rdy is high
        out_ready = 1'b0;
        for (int unsigned v = 50; v <= 52; v++) pulse(v);
        check("t6_level", fifo_level, 3);
        result        = 32'd77;
        result_parity = ^result;
        result_rdy    = 1'b1;
        rst           = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_cnt_results", cnt_results, 0);
        check("t6_rst_cnt_par_err", cnt_par_err, 0);
        check("t6_rst_cnt_drop", cnt_drop, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t6_cnt_results", cnt_results, 1);
        check("t6_valid", out_valid, 1);
        check("t6_result", out_result, 77);
        result_rdy = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        check("t6_empty", out_valid, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
